// File: rtl/async_fifo_flags_if.sv
// Signal bundle between a producer/consumer pair and the dual-clock FIFO.
// Write-side and read-side signals share one bundle; each side only touches its own domain's signals.
interface async_fifo_flags_if #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
);
   logic             winc;
   logic [DSIZE-1:0] wdata;
   logic             wfull;
   logic             walmost_full;
   logic [ASIZE:0]   wlevel;
   logic             woverflow;
   logic             rinc;
   logic [DSIZE-1:0] rdata;
   logic             rempty;
   logic             ralmost_empty;
   logic [ASIZE:0]   rlevel;
   logic             runderflow;

   modport master (
      output winc, wdata, rinc,
      input  wfull, walmost_full, wlevel, woverflow,
      input  rdata, rempty, ralmost_empty, rlevel, runderflow
   );

   modport slave (
      input  winc, wdata, rinc,
      output wfull, walmost_full, wlevel, woverflow,
      output rdata, rempty, ralmost_empty, rlevel, runderflow
   );
endinterface

// File: rtl/async_fifo_flags.sv
// Dual-clock FIFO with Gray-coded pointer crossings, per-domain fill levels,
// almost-full/almost-empty thresholds, sticky error flags and optional FWFT read.
module async_fifo_flags #(
   parameter int DSIZE       = 8,
   parameter int ASIZE       = 4,
   parameter int AF_LEVEL    = (1 << ASIZE) - 2,
   parameter int AE_LEVEL    = 2,
   parameter int FWFT        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              wclk,
   input  logic              wrst_n,
   input  logic              rclk,
   input  logic              rrst_n,
   async_fifo_flags_if.slave fifo
);

   localparam int DEPTH = 1 << ASIZE;

   typedef logic [ASIZE:0] ptr_t;

   localparam ptr_t AF_THR = ptr_t'(AF_LEVEL);
   localparam ptr_t AE_THR = ptr_t'(AE_LEVEL);

   logic [DSIZE-1:0] mem [DEPTH];

   ptr_t wptr_bin, wptr_gray, wbin_next;
   ptr_t rptr_bin, rptr_gray, rbin_next;
   ptr_t rptr_gray_wsync [SYNC_STAGES];
   ptr_t wptr_gray_rsync [SYNC_STAGES];
   ptr_t rptr_gray_ws, wptr_gray_rs;
   ptr_t rptr_bin_wsync, wptr_bin_rsync;
   ptr_t wlevel, rlevel;
   logic wfull, rempty;
   logic write_ok, read_ok;
   logic woverflow_q, runderflow_q;
   logic [DSIZE-1:0] rdata;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[ASIZE] = g[ASIZE];
      for (int i = ASIZE - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Write domain: pointer advance and sticky overflow when a write hits a full FIFO.
   assign write_ok  = fifo.winc && !wfull;
   assign wbin_next = wptr_bin + ptr_t'(write_ok);

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wptr_bin     <= '0;
         wptr_gray    <= '0;
         woverflow_q  <= 1'b0;
      end else begin
         wptr_bin  <= wbin_next;
         wptr_gray <= bin2gray(wbin_next);
         if (fifo.winc && wfull) begin
            woverflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge wclk) begin
      if (write_ok) begin
         mem[wptr_bin[ASIZE-1:0]] <= fifo.wdata;
      end
   end

   // Read pointer crossing into the write domain.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            rptr_gray_wsync[i] <= '0;
         end
      end else begin
         rptr_gray_wsync[0] <= rptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            rptr_gray_wsync[i] <= rptr_gray_wsync[i-1];
         end
      end
   end

   // Write-side flags use a stale read pointer, so they can only overstate occupancy.
   assign rptr_gray_ws   = rptr_gray_wsync[SYNC_STAGES-1];
   assign rptr_bin_wsync = gray2bin(rptr_gray_ws);
   assign wfull          = (wptr_gray == {~rptr_gray_ws[ASIZE:ASIZE-1], rptr_gray_ws[ASIZE-2:0]});
   assign wlevel         = wptr_bin - rptr_bin_wsync;

   assign fifo.wfull        = wfull;
   assign fifo.wlevel       = wlevel;
   assign fifo.walmost_full = (wlevel >= AF_THR);
   assign fifo.woverflow    = woverflow_q;

   // Read domain: pointer advance and sticky underflow when a read hits an empty FIFO.
   assign read_ok   = fifo.rinc && !rempty;
   assign rbin_next = rptr_bin + ptr_t'(read_ok);

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rptr_bin     <= '0;
         rptr_gray    <= '0;
         runderflow_q <= 1'b0;
      end else begin
         rptr_bin  <= rbin_next;
         rptr_gray <= bin2gray(rbin_next);
         if (fifo.rinc && rempty) begin
            runderflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            wptr_gray_rsync[i] <= '0;
         end
      end else begin
         wptr_gray_rsync[0] <= wptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            wptr_gray_rsync[i] <= wptr_gray_rsync[i-1];
         end
      end
   end

   assign wptr_gray_rs   = wptr_gray_rsync[SYNC_STAGES-1];
   assign wptr_bin_rsync = gray2bin(wptr_gray_rs);
   assign rempty         = (rptr_gray == wptr_gray_rs);
   assign rlevel         = wptr_bin_rsync - rptr_bin;

   assign fifo.rempty        = rempty;
   assign fifo.rlevel        = rlevel;
   assign fifo.ralmost_empty = (rlevel <= AE_THR);
   assign fifo.runderflow    = runderflow_q;

   // FWFT exposes the head word directly; otherwise the popped word is registered.
   generate
      if (FWFT != 0) begin : g_fwft
         assign rdata = mem[rptr_bin[ASIZE-1:0]];
      end else begin : g_reg
         always_ff @(posedge rclk or negedge rrst_n) begin
            if (!rrst_n) begin
               rdata <= '0;
            end else if (read_ok) begin
               rdata <= mem[rptr_bin[ASIZE-1:0]];
            end
         end
      end
   endgenerate

   assign fifo.rdata = rdata;

endmodule

// File: tb/tb_async_fifo_flags.sv
// Self-checking bench for async_fifo_flags: table-driven fill, scoreboard-checked reads,
// overflow/underflow, joint reset, randomised streaming at two clock ratios, and FWFT.
`timescale 1ns/1ps
module tb_async_fifo_flags;

   localparam int AF = 6;
   localparam int AE = 1;

   logic wclk = 1'b0;
   logic rclk = 1'b0;
   logic wrst_n = 1'b0;
   logic rrst_n = 1'b0;
   real  whalf = 5.0;
   real  rhalf = 8.5;

   int vec_count = 0;
   int err_count = 0;
   logic [7:0] sb_q[$];
   logic [7:0] stream_base = 8'h00;

   typedef struct {
      logic [7:0] wdata;
      logic       exp_wfull;
      logic [3:0] exp_wlevel;
      logic       exp_waf;
   } fill_vec_t;

   fill_vec_t fill_tbl [8];

   async_fifo_flags_if #(.DSIZE(8), .ASIZE(3)) f0 ();
   async_fifo_flags_if #(.DSIZE(8), .ASIZE(3)) f1 ();

   async_fifo_flags #(.DSIZE(8), .ASIZE(3), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0), .SYNC_STAGES(2)) dut0 (
      .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n), .fifo(f0.slave)
   );

   async_fifo_flags #(.DSIZE(8), .ASIZE(3), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1), .SYNC_STAGES(2)) dut1 (
      .wclk(wclk), .wrst_n(wrst_n), .rclk(rclk), .rrst_n(rrst_n), .fifo(f1.slave)
   );

   always #(whalf) wclk = ~wclk;
   always #(rhalf) rclk = ~rclk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_count++;
      if (act !== exp) begin
         err_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string why);
      vec_count++;
      err_count++;
      $display("[TB] FAIL %s: %s", name, why);
   endtask

   task automatic pop_check(input string name, input logic [7:0] act);
      logic [7:0] exp;
      if (sb_q.size() == 0) begin
         fail_now(name, "read data with empty scoreboard");
      end else begin
         exp = sb_q.pop_front();
         check_output(name, 32'(act), 32'(exp));
      end
   endtask

   task automatic check_reset(input string tag);
      check_output({tag, "_wfull"},  32'(f0.wfull), 32'd0);
      check_output({tag, "_waf"},    32'(f0.walmost_full), 32'd0);
      check_output({tag, "_wlevel"}, 32'(f0.wlevel), 32'd0);
      check_output({tag, "_wovf"},   32'(f0.woverflow), 32'd0);
      check_output({tag, "_rempty"}, 32'(f0.rempty), 32'd1);
      check_output({tag, "_rae"},    32'(f0.ralmost_empty), 32'd1);
      check_output({tag, "_rlevel"}, 32'(f0.rlevel), 32'd0);
      check_output({tag, "_runf"},   32'(f0.runderflow), 32'd0);
      check_output({tag, "_rdata"},  32'(f0.rdata), 32'd0);
   endtask

   task automatic apply_stimulus(input logic [7:0] d);
      @(negedge wclk);
      f0.winc  = 1'b1;
      f0.wdata = d;
      @(posedge wclk);
      #1;
      f0.winc  = 1'b0;
   endtask

   task automatic read_word(output logic [7:0] d);
      @(negedge rclk);
      f0.rinc = 1'b1;
      @(posedge rclk);
      #1;
      f0.rinc = 1'b0;
      d = f0.rdata;
   endtask

   task automatic wait_not_empty(input string name);
      int cnt;
      cnt = 0;
      while (f0.rempty && cnt < 20) begin
         @(negedge rclk);
         cnt++;
      end
      if (f0.rempty) fail_now(name, "timed out waiting for rempty=0");
   endtask

   // Producer and consumer run concurrently; each respects only its own domain's flag.
   task automatic run_stream(input string tag, input int n);
      fork
         begin
            for (int i = 0; i < n; i++) begin
               int cnt;
               repeat ($urandom_range(0, 2)) @(posedge wclk);
               @(negedge wclk);
               cnt = 0;
               while (f0.wfull && cnt < 500) begin
                  @(negedge wclk);
                  cnt++;
               end
               if (f0.wfull) begin
                  fail_now({tag, "_wr"}, "timed out waiting for wfull=0");
                  break;
               end
               f0.winc  = 1'b1;
               f0.wdata = stream_base + 8'(i);
               sb_q.push_back(stream_base + 8'(i));
               @(posedge wclk);
               #1;
               f0.winc = 1'b0;
            end
         end
         begin
            int got;
            int budget;
            got = 0;
            budget = 0;
            while (got < n && budget < 6000) begin
               @(negedge rclk);
               budget++;
               if (!f0.rempty && $urandom_range(0, 3) != 0) begin
                  f0.rinc = 1'b1;
                  @(posedge rclk);
                  #1;
                  f0.rinc = 1'b0;
                  got++;
                  pop_check({tag, "_data"}, f0.rdata);
               end
            end
            if (got < n) fail_now({tag, "_rd"}, "timed out before all words were read");
         end
      join
      stream_base = stream_base + 8'(n);
   endtask

   initial begin
      logic [7:0] d;
      int cnt;

      f0.winc = 1'b0; f0.wdata = '0; f0.rinc = 1'b0;
      f1.winc = 1'b0; f1.wdata = '0; f1.rinc = 1'b0;

      for (int i = 0; i < 8; i++) begin
         fill_tbl[i] = '{wdata: 8'(i + 1), exp_wfull: (i == 7), exp_wlevel: 4'(i + 1), exp_waf: ((i + 1) >= AF)};
      end

      #20;
      check_reset("por");
      check_output("por_fwft_rempty", 32'(f1.rempty), 32'd1);
      @(negedge wclk);
      wrst_n = 1'b1;
      rrst_n = 1'b1;
      repeat (3) @(posedge rclk);

      // Fill with no reads; write-side status follows each accepted write immediately.
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(fill_tbl[i].wdata);
         sb_q.push_back(fill_tbl[i].wdata);
         check_output($sformatf("fill%0d_wfull", i), 32'(f0.wfull), 32'(fill_tbl[i].exp_wfull));
         check_output($sformatf("fill%0d_wlevel", i), 32'(f0.wlevel), 32'(fill_tbl[i].exp_wlevel));
         check_output($sformatf("fill%0d_waf", i), 32'(f0.walmost_full), 32'(fill_tbl[i].exp_waf));
      end
      repeat (3) @(posedge rclk);
      #1;
      check_output("fill_rlevel", 32'(f0.rlevel), 32'd8);
      check_output("fill_rempty", 32'(f0.rempty), 32'd0);
      check_output("fill_rae",    32'(f0.ralmost_empty), 32'd0);

      apply_stimulus(8'h99);
      check_output("ovf_flag",   32'(f0.woverflow), 32'd1);
      check_output("ovf_wlevel", 32'(f0.wlevel), 32'd8);
      check_output("ovf_wfull",  32'(f0.wfull), 32'd1);
      repeat (5) @(posedge wclk);
      #1;
      check_output("ovf_sticky", 32'(f0.woverflow), 32'd1);

      for (int i = 0; i < 8; i++) begin
         read_word(d);
         pop_check($sformatf("drain%0d", i), d);
      end
      check_output("drain_rempty", 32'(f0.rempty), 32'd1);
      check_output("drain_rlevel", 32'(f0.rlevel), 32'd0);
      check_output("drain_rae",    32'(f0.ralmost_empty), 32'd1);

      read_word(d);
      check_output("unf_flag",   32'(f0.runderflow), 32'd1);
      check_output("unf_rdata",  32'(d), 32'h08);
      check_output("unf_rempty", 32'(f0.rempty), 32'd1);
      check_output("unf_rlevel", 32'(f0.rlevel), 32'd0);
      repeat (3) @(posedge wclk);
      #1;
      check_output("drain_wlevel", 32'(f0.wlevel), 32'd0);
      check_output("drain_wfull",  32'(f0.wfull), 32'd0);

      // Joint reset with words still held; outputs must clear without waiting for a clock.
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(8'h31 + 8'(i));
         sb_q.push_back(8'h31 + 8'(i));
      end
      repeat (3) @(posedge rclk);
      #1;
      check_output("held_rlevel", 32'(f0.rlevel), 32'd5);
      #3;
      wrst_n = 1'b0;
      rrst_n = 1'b0;
      #1;
      check_reset("mid");
      sb_q.delete();
      #20;
      @(negedge wclk);
      wrst_n = 1'b1;
      rrst_n = 1'b1;
      repeat (3) @(posedge rclk);

      apply_stimulus(8'h5A);
      sb_q.push_back(8'h5A);
      apply_stimulus(8'h5B);
      sb_q.push_back(8'h5B);
      @(negedge rclk);
      wait_not_empty("post_rst");
      read_word(d);
      pop_check("post_rst_first", d);
      wait_not_empty("post_rst2");
      read_word(d);
      pop_check("post_rst_second", d);

      run_stream("s10_17", 100);
      whalf = 8.5;
      rhalf = 5.0;
      run_stream("s17_10", 100);
      check_output("stream_wovf",  32'(f0.woverflow), 32'd0);
      check_output("stream_runf",  32'(f0.runderflow), 32'd0);
      check_output("stream_left",  32'(sb_q.size()), 32'd0);
      whalf = 5.0;
      rhalf = 8.5;

      // FWFT instance: head word visible without a pop.
      @(negedge wclk);
      f1.winc  = 1'b1;
      f1.wdata = 8'hA5;
      @(posedge wclk);
      #1;
      f1.winc = 1'b0;
      cnt = 0;
      while (f1.rempty && cnt < 20) begin
         @(negedge rclk);
         cnt++;
      end
      check_output("fwft_rempty0", 32'(f1.rempty), 32'd0);
      check_output("fwft_rdata",   32'(f1.rdata), 32'hA5);
      @(negedge rclk);
      f1.rinc = 1'b1;
      @(posedge rclk);
      #1;
      f1.rinc = 1'b0;
      check_output("fwft_rempty1", 32'(f1.rempty), 32'd1);
      check_output("fwft_runf",    32'(f1.runderflow), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule

// File: doc/async_fifo_flags.md
# async_fifo_flags

Parametrised dual-clock FIFO for crossing data between unrelated write and read clock domains, with Gray-coded pointer synchronisers of configurable depth. It adds per-domain fill levels, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and an optional first-word-fall-through read mode. It is the standard clock-domain-crossing buffer between producer and consumer blocks.

## Interface

- DSIZE, 8: data width in bits.
- ASIZE, 4: address width; DEPTH = 2^ASIZE entries; ASIZE >= 2.
- AF_LEVEL, DEPTH-2: walmost_full threshold; 1..DEPTH.
- AE_LEVEL, 2: ralmost_empty threshold; 0..DEPTH-1.
- FWFT, 0: 0 = registered read; 1 = first-word-fall-through.
- SYNC_STAGES, 2: synchroniser flops per crossing; 2..4.

- wclk  in  1  write clock; reset wrst_n, asynchronous, active-low; clock wclk.
- wrst_n  in  1  write-domain reset, asynchronous, active-low.
- rclk  in  1  read clock.
- rrst_n  in  1  read-domain reset, asynchronous, active-low.
- winc  in  1  write request.
- wdata  in  DSIZE  write data.
- wfull  out  1  FIFO full (write view).
- walmost_full  out  1  wlevel >= AF_LEVEL.
- wlevel  out  ASIZE+1  occupancy seen by write side, 0..DEPTH.
- woverflow  out  1  sticky: write attempted while full.
- rinc  in  1  read request / pop.
- rdata  out  DSIZE  read data.
- rempty  out  1  FIFO empty (read view).
- ralmost_empty  out  1  rlevel <= AE_LEVEL.
- rlevel  out  ASIZE+1  occupancy seen by read side, 0..DEPTH.
- runderflow  out  1  sticky: read attempted while empty.

## Operation

- Storage: DEPTH x DSIZE array, written in wclk domain only.
- Pointers: (ASIZE+1)-bit binary and Gray pointers per domain; Gray = bin ^ (bin >> 1). The MSB is the wrap bit.
- Each Gray pointer crosses into the other domain through SYNC_STAGES flops. The synchronised value is converted back to binary for level computation.
- Write: accepted iff winc && !wfull. Then mem[wptr[ASIZE-1:0]] <= wdata and wptr increments mod 2^(ASIZE+1).
- winc && wfull: write dropped, no state change, woverflow <= 1.
- Read: accepted iff rinc && !rempty; rptr increments.
- rinc && rempty: no state change, runderflow <= 1.
- Sticky flags clear only on their domain reset.
- FWFT=0: rdata registered. On an accepted read, rdata <= mem[rptr] at that rclk edge. Otherwise rdata holds its value.
- FWFT=1: rdata = mem[rptr[ASIZE-1:0]] continuously, so the head word is valid whenever rempty=0. An accepted rinc pops it, and the next word appears after that edge.
- wfull = (wptr_gray == sync rptr_gray with its top two bits inverted).
- rempty = (rptr_gray == sync wptr_gray).
- wlevel = wptr_bin - rptr_bin_sync; rlevel = wptr_bin_sync - rptr_bin. Both are computed mod 2^(ASIZE+1), and the result is always in 0..DEPTH.
- All status outputs are registered or derived only from registered same-domain state. They are never derived from unsynchronised cross-domain signals.
- Status is pessimistic: full and level may overstate occupancy on the write side, and empty and level may understate it on the read side. The FIFO never overflows or underflows its storage.

## Timing

- Reset values: wfull=0, walmost_full=(AF_LEVEL==0 ? 1 : 0) (always 0 within the legal range), wlevel=0, woverflow=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0, rdata=0 (FWFT=0).
- wrst_n and rrst_n are asserted together, system-wide. Asserting either alone mid-operation leaves the contents undefined. The resetting domain's outputs still go to their reset values immediately.
- Write-to-read latency: a write at wclk edge N is visible to rempty/rlevel after SYNC_STAGES rising rclk edges following edge N. With SYNC_STAGES=2 that is the 2nd rclk edge, plus up to one rclk of metastability-resolution uncertainty.
- Read-to-write latency (wfull release, wlevel decrement): symmetric, SYNC_STAGES wclk edges.
- wfull asserts in the same wclk cycle as the write that fills the FIFO, i.e. it is visible after that edge. rempty asserts likewise after the read that empties it.
- Simultaneous winc and rinc in their own domains are independent. There is no combined arbitration.
- Wrap-around: pointers roll from 2^(ASIZE+1)-1 to 0 seamlessly, and level arithmetic stays correct across the wrap.

## Test plan

All scenarios use DSIZE=8, ASIZE=3 (DEPTH=8), AF_LEVEL=6, AE_LEVEL=1, and wclk:rclk = 10ns:17ns unless noted.

- Reset, then write 0x01..0x08 with no reads -> wfull=1 after the 8th write, wlevel=8, walmost_full=1 from the 6th write. rlevel reaches 8 and rempty=0 within 2 rclk edges of the final write.
- Full FIFO, winc with 0x99 -> dropped, woverflow=1 and stays 1. Reading 8 words yields 0x01..0x08 in order, never 0x99.
- Empty FIFO, rinc pulse -> runderflow=1, rdata unchanged, rlevel=0, rempty=1.
- Stream 100 words through with random winc/rinc and clock ratios 10:17 and 17:10 -> output sequence matches input exactly, no overflow or underflow flags, and the pointers wrap more than 10 times.
- FWFT=1: write 0xA5 -> once rempty=0, rdata=0xA5 without rinc. After one rinc, rempty=1 following the edge.
- Mid-stream joint reset with 5 words held -> all outputs return to their reset values asynchronously. After release, the first written word is the first word read.
